// File: rtl/fetch_queue_if.sv
// Fetch queue bus bundle: redirect inputs, instruction-memory handshake and
// the decoded head-of-queue outputs toward IF/ID.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             redir_early_en;
  logic [31:0]      redir_early_pc;
  logic             redir_en;
  logic [31:0]      redir_pc;

  logic [31:0]      iaddr;
  logic             ireq;
  logic             iready_n;
  logic [31:0]      idata;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [31:0]      out_pc;
  logic [31:0]      out_pcp4;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [CNT_W-1:0] count;

  modport master (
    input  redir_early_en, redir_early_pc, redir_en, redir_pc,
    input  iready_n, idata, out_ready,
    output iaddr, ireq,
    output out_valid, out_instr, out_pc, out_pcp4, out_rs1, out_rs2, count
  );

  modport slave (
    output redir_early_en, redir_early_pc, redir_en, redir_pc,
    output iready_n, idata, out_ready,
    input  iaddr, ireq,
    input  out_valid, out_instr, out_pc, out_pcp4, out_rs1, out_rs2, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch unit: sequential address generator feeding a small
// circular instruction buffer, flushed by execute/decode-stage redirects.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0001_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master fq
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t           entries_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      pc_q;

  logic             valid_c;
  logic             pop_c;
  logic             ireq_c;
  logic             redir_c;
  logic             accept_c;
  logic [31:0]      target_c;
  entry_t           head_c;

  // Handshake decode and head-entry selection
  always_comb begin
    valid_c  = 1'b0;
    pop_c    = 1'b0;
    ireq_c   = 1'b0;
    redir_c  = 1'b0;
    accept_c = 1'b0;
    target_c = '0;
    head_c   = '{pc: 32'h0, instr: NOP};

    valid_c  = (cnt_q != '0);
    pop_c    = valid_c & fq.out_ready;
    ireq_c   = (cnt_q < CNT_W'(DEPTH)) | pop_c;
    redir_c  = fq.redir_en | fq.redir_early_en;
    // Execute-stage redirect belongs to the older instruction, so it wins
    target_c = fq.redir_en ? fq.redir_pc : fq.redir_early_pc;
    accept_c = ireq_c & ~fq.iready_n & ~redir_c;
    if (valid_c) begin
      head_c = entries_q[head_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      cnt_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else if (redir_c) begin
      pc_q   <= {target_c[31:2], 2'b00};
      cnt_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (accept_c) begin
        pc_q   <= pc_q + 32'd4;
        tail_q <= tail_q + PTR_W'(1);
      end
      if (pop_c) begin
        head_q <= head_q + PTR_W'(1);
      end
      cnt_q <= cnt_q + CNT_W'(accept_c) - CNT_W'(pop_c);
    end
  end

  // Buffer storage has no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (rst && accept_c) begin
      entries_q[tail_q] <= '{pc: pc_q, instr: fq.idata};
    end
  end

  assign fq.iaddr     = pc_q;
  assign fq.ireq      = ireq_c;
  assign fq.count     = cnt_q;
  assign fq.out_valid = valid_c;
  assign fq.out_instr = head_c.instr;
  assign fq.out_pc    = head_c.pc;
  assign fq.out_pcp4  = valid_c ? head_c.pc + 32'd4 : 32'h0;
  assign fq.out_rs1   = head_c.instr[19:15];
  assign fq.out_rs2   = head_c.instr[24:20];
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, back-pressure, memory wait,
// redirect priority/alignment, address wrap and reset override.
module tb_fetch_queue;
  localparam logic [31:0] TAG = 32'hC0DE_0000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fetch_queue_if #(.DEPTH(4)) fq ();

  fetch_queue #(.RESET_PC(32'h0001_0000), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .fq  (fq.master)
  );

  // Memory returns an address-tagged word for whatever is requested
  assign fq.idata = fq.iaddr ^ TAG;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    fq.redir_early_en = 1'b0;
    fq.redir_early_pc = 32'h0;
    fq.redir_en       = 1'b0;
    fq.redir_pc       = 32'h0;
    fq.iready_n       = 1'b1;
    fq.out_ready      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) tick();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    idle_inputs();

    // Reset state and first cycle after release
    do_reset();
    check("rst_count",  32'(fq.count), 32'd0);
    check("rst_valid",  32'(fq.out_valid), 32'd0);
    check("rst_instr",  fq.out_instr, 32'h0000_0013);
    check("rst_pc",     fq.out_pc, 32'h0);
    check("rst_pcp4",   fq.out_pcp4, 32'h0);
    check("rst_iaddr",  fq.iaddr, 32'h0001_0000);
    check("rst_ireq",   32'(fq.ireq), 32'd1);

    // Streaming: one instruction per cycle, in order
    fq.iready_n  = 1'b0;
    fq.out_ready = 1'b1;
    tick();
    check("s1_pc0",   fq.out_pc, 32'h0001_0000);
    check("s1_rs1",   32'(fq.out_rs1), 32'd30);
    check("s1_rs2",   32'(fq.out_rs2), 32'd13);
    check("s1_cnt0",  32'(fq.count), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("s1_pc",    fq.out_pc, 32'h0001_0000 + 32'(4 * k));
      check("s1_pcp4",  fq.out_pcp4, 32'h0001_0004 + 32'(4 * k));
      check("s1_instr", fq.out_instr, (32'h0001_0000 + 32'(4 * k)) ^ TAG);
      check("s1_cnt",   32'(fq.count), 32'd1);
    end

    // Back-pressure: fill to DEPTH, then full+pop+accept, then in-order drain
    do_reset();
    fq.iready_n  = 1'b0;
    fq.out_ready = 1'b0;
    repeat (6) tick();
    check("s2_cnt_full", 32'(fq.count), 32'd4);
    check("s2_ireq0",    32'(fq.ireq), 32'd0);
    check("s2_iaddr",    fq.iaddr, 32'h0001_0010);
    check("s2_head",     fq.out_pc, 32'h0001_0000);
    fq.out_ready = 1'b1;
    #1;
    check("s2_ireq_pop", 32'(fq.ireq), 32'd1);
    tick();
    check("s2_fpa_cnt",   32'(fq.count), 32'd4);
    check("s2_fpa_head",  fq.out_pc, 32'h0001_0004);
    check("s2_fpa_iaddr", fq.iaddr, 32'h0001_0014);
    fq.iready_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("s2_drain_pc",    fq.out_pc, 32'h0001_0004 + 32'(4 * k));
      check("s2_drain_instr", fq.out_instr, (32'h0001_0004 + 32'(4 * k)) ^ TAG);
      check("s2_drain_cnt",   32'(fq.count), 32'(4 - k));
      tick();
    end
    check("s2_empty_valid", 32'(fq.out_valid), 32'd0);
    check("s2_empty_iaddr", fq.iaddr, 32'h0001_0014);

    // Memory wait mid-stream
    do_reset();
    fq.iready_n  = 1'b0;
    fq.out_ready = 1'b1;
    repeat (2) tick();
    fq.iready_n = 1'b1;
    tick();
    check("s3_valid", 32'(fq.out_valid), 32'd0);
    check("s3_iaddr", fq.iaddr, 32'h0001_0008);
    check("s3_ireq",  32'(fq.ireq), 32'd1);
    repeat (2) tick();
    check("s3_hold_iaddr", fq.iaddr, 32'h0001_0008);
    check("s3_hold_cnt",   32'(fq.count), 32'd0);
    check("s3_hold_pc",    fq.out_pc, 32'h0);
    fq.iready_n = 1'b0;
    tick();
    check("s3_resume_pc",  fq.out_pc, 32'h0001_0008);
    check("s3_resume_cnt", 32'(fq.count), 32'd1);

    // Simultaneous redirects with count=3: execute-stage target wins
    do_reset();
    fq.iready_n  = 1'b0;
    fq.out_ready = 1'b0;
    repeat (3) tick();
    check("s4_cnt3", 32'(fq.count), 32'd3);
    fq.redir_en       = 1'b1;
    fq.redir_pc       = 32'h0001_0100;
    fq.redir_early_en = 1'b1;
    fq.redir_early_pc = 32'h0001_0200;
    tick();
    check("s4_iaddr", fq.iaddr, 32'h0001_0100);
    check("s4_cnt",   32'(fq.count), 32'd0);
    check("s4_instr", fq.out_instr, 32'h0000_0013);
    check("s4_valid", 32'(fq.out_valid), 32'd0);
    fq.redir_en       = 1'b0;
    fq.redir_early_en = 1'b0;
    tick();
    check("s4_new_head",  fq.out_pc, 32'h0001_0100);
    check("s4_new_iaddr", fq.iaddr, 32'h0001_0104);

    // Early redirect alignment, then address wrap at the top of memory
    fq.redir_early_en = 1'b1;
    fq.redir_early_pc = 32'h0001_0203;
    tick();
    check("s5_align", fq.iaddr, 32'h0001_0200);
    check("s5_cnt",   32'(fq.count), 32'd0);
    fq.redir_early_en = 1'b0;
    fq.redir_en       = 1'b1;
    fq.redir_pc       = 32'hFFFF_FFFF;
    tick();
    check("s5_top", fq.iaddr, 32'hFFFF_FFFC);
    fq.redir_en = 1'b0;
    tick();
    check("s5_wrap_iaddr", fq.iaddr, 32'h0000_0000);
    check("s5_wrap_pc",    fq.out_pc, 32'hFFFF_FFFC);
    check("s5_wrap_pcp4",  fq.out_pcp4, 32'h0000_0000);

    // Reset overrides a pending redirect and discards buffered entries
    do_reset();
    fq.iready_n  = 1'b0;
    fq.out_ready = 1'b0;
    repeat (2) tick();
    check("s6_cnt2", 32'(fq.count), 32'd2);
    fq.redir_en = 1'b1;
    fq.redir_pc = 32'h0001_0100;
    rst         = 1'b0;
    tick();
    check("s6_iaddr", fq.iaddr, 32'h0001_0000);
    check("s6_cnt",   32'(fq.count), 32'd0);
    check("s6_valid", 32'(fq.out_valid), 32'd0);
    rst         = 1'b1;
    fq.redir_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0001_0000, meaning the fetch address loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the instruction-buffer entry count; legal values are powers of two, 2..16.
REQ-003 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port redir_early_en  in  1  decode-stage early-branch redirect request.
REQ-006 SHALL have port redir_early_pc  in  32  early-branch target.
REQ-007 SHALL have port redir_en  in  1  execute-stage branch/jump redirect request.
REQ-008 SHALL have port redir_pc  in  32  execute-stage target.
REQ-009 SHALL have port iaddr  out  32  instruction-memory address, registered.
REQ-010 SHALL have port ireq  out  1  fetch request for iaddr this cycle.
REQ-011 SHALL have port iready_n  in  1  low = idata valid for iaddr this cycle.
REQ-012 SHALL have port idata  in  32  instruction word from memory.
REQ-013 SHALL have port out_valid  out  1  head entry present.
REQ-014 SHALL have port out_ready  in  1  consumer (IF/ID) accepts head this cycle.
REQ-015 SHALL have ports out_instr / out_pc / out_pcp4  out  32 each  head instruction, its PC, PC+4.
REQ-016 SHALL have ports out_rs1 / out_rs2  out  5 each  out_instr[19:15] / out_instr[24:20].
REQ-017 SHALL have port count  out  clog2(DEPTH)+1  current occupancy.

Function
REQ-018 SHALL define pop = out_valid & out_ready, and out_valid = (count != 0).
REQ-019 SHALL drive ireq = (count < DEPTH) | pop, combinationally.
REQ-020 SHALL define accept = ireq & ~iready_n & ~redir_en & ~redir_early_en.
REQ-021 On accept, SHALL write {iaddr, iaddr+4, idata} at the tail and advance iaddr to iaddr+4 (mod 2^32) at the next edge.
REQ-022 When ireq=1 and iready_n=1, SHALL hold iaddr and not write (memory wait).
REQ-023 When count=DEPTH and no pop, SHALL hold iaddr; an idata returned that cycle is dropped and re-fetched.
REQ-024 Push and pop in the same cycle SHALL leave count unchanged; full+pop+accept SHALL be legal.
REQ-025 Head/tail pointers SHALL wrap modulo DEPTH.
REQ-026 Redirect priority SHALL be: redir_en over redir_early_en (older instruction wins).
REQ-027 On any redirect, SHALL next-edge set iaddr = selected target with bits [1:0] forced to 0, count=0, head=tail=0; data returned that cycle is discarded.
REQ-028 A pop coincident with a redirect SHALL count as consumed by the consumer; the buffer still flushes.
REQ-029 When count=0, SHALL drive out_instr=32'h0000_0013 (addi x0,x0,0), out_pc=out_pcp4=0, out_rs1=out_rs2=0.
REQ-030 Fetch-to-output latency SHALL be one cycle: an accepted word is visible at the head on the next cycle if the buffer was empty.
REQ-031 The head outputs SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-032 With rst=0 at a clock edge, SHALL set iaddr=RESET_PC, count=0, pointers=0, out_valid=0, out_instr=32'h0000_0013.
REQ-033 Reset SHALL override redirects and accepts in the same cycle; reset mid-stall SHALL discard all entries.
REQ-034 In the first cycle after rst=1, SHALL assert ireq=1 with iaddr=RESET_PC.

Verification
REQ-035 Scenario: reset, then iready_n=0, out_ready=1, memory returns addr-tagged words -> out_pc=0x10000, 0x10004, 0x10008... one per cycle, with out_pcp4=out_pc+4.
REQ-036 Scenario: out_ready=0 for 6 cycles, DEPTH=4 -> count saturates at 4, ireq=0, iaddr=0x10010 held; out_ready=1 -> in-order drain with no loss or duplicate.
REQ-037 Scenario: iready_n=1 for 3 cycles mid-stream -> iaddr held, no push, out_valid falls once the buffer empties.
REQ-038 Scenario: redir_en=1 (pc=0x10100) and redir_early_en=1 (pc=0x10200) together with count=3 -> next cycle iaddr=0x10100, count=0, out_instr=0x00000013.
REQ-039 Scenario: redir_early_pc=0x10203 -> iaddr=0x10200; iaddr=0xFFFF_FFFC accepted -> next iaddr=0x0000_0000.
REQ-040 Scenario: rst=0 asserted with count=2 and a pending redirect -> iaddr=RESET_PC, count=0.
